i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Shares the single I2C master front end (start_gen and its downstream byte engine) between two requester ports.
- Latches one transaction (address, rw, write byte), then drives the master's cs/wr/rd strobe for a programmable number of clk cycles.
- Waits for the master's stop indication, returns read data and completion status to the winning requester, and enforces a bus-free gap between transactions.
- Arbitration is round-robin. An optional lock holds the bus for a repeated-start sequence.

Parameters:
- CS_CYCLES, 4: clk cycles m_cs plus m_wr/m_rd are held high per issue (1..15).
- GAP_CYCLES, 8: idle clk cycles after a transaction before the next grant (0..255).
- TIMEOUT_CYCLES, 1000: WAIT-state watchdog limit, used only with I2C_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req0, req1  in  1  transaction request, level; must stay high until ack
- rw0, rw1  in  1  1=read, 0=write
- addr0, addr1  in  7  7-bit slave address
- wdata0, wdata1  in  8  write byte
- lock0, lock1  in  1  keep grant after done; repeated start, no stop
- ack0, ack1  out  1  one-cycle pulse: request latched
- done0, done1  out  1  one-cycle pulse: transaction complete
- err0, err1  out  1  one-cycle pulse with done: timeout
- rdata0, rdata1  out  8  read byte, valid from done, held until that port's next done
- m_cs, m_wr, m_rd  out  1  strobes to master
- m_addr  out  7  latched address
- m_wdata  out  8  latched write byte
- m_hold  out  1  repeated-start hold to master
- m_stop  in  1  master stop/complete, level
- m_rdata  in  8  master read byte, valid while m_stop=1
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, last_grant=1 so port 0 wins first, counters 0.
- States: IDLE, ISSUE, WAIT, DONE, GAP.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the port != last_grant.
  - Latch addr/rw/wdata into m_addr/m_wdata/rw_q and pulse ackN for 1 cycle (cycle after req is seen).
  - Next state ISSUE.
- ISSUE: m_cs=1, m_wr=~rw_q, m_rd=rw_q for exactly CS_CYCLES cycles, then all three go 0 and state moves to WAIT.
- WAIT: on the first cycle with m_stop=1 (registered sample):
  - If rw_q=1, capture m_rdata into rdataN.
  - Go to DONE.
  - req changes during WAIT are ignored.
- DONE: 1 cycle; doneN=1; last_grant=N.
  - If lockN=1 and reqN=1: m_hold=1, latch the new request immediately, pulse ackN, go to ISSUE (skip GAP, no arbitration).
  - Otherwise: m_hold=0, go to GAP.
- GAP: count GAP_CYCLES cycles, then IDLE. GAP_CYCLES=0 means direct to IDLE.
- Outside a locked chain, m_hold is 0 in every state. In a locked chain it stays 1 from DONE through the following ISSUE and WAIT.
- Minimum request-to-ack latency: 1 cycle. A request arriving during a transaction waits; it is never dropped.
- m_stop already high on WAIT entry: completes on the first WAIT cycle.
- rst mid-transaction: all strobes and pulses drop immediately; latched data is discarded; no done is issued.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT.
  - Reaching TIMEOUT_CYCLES without m_stop forces DONE with errN=1 and rdataN=8'hFF.
  - Lock is ignored on error, so the state always goes to GAP and m_hold=0.
- Undefined:
  - No counter; WAIT holds indefinitely.
  - err0/err1 are tied 0.

Test Plan:
- Single write: req0=1, rw0=0, addr0=7'h51, wdata0=8'h14. Expect ack0 one cycle later; m_cs=m_wr=1 for 4 cycles with m_addr=7'h51, m_wdata=8'h14. Raise m_stop -> done0 pulse, then 8 GAP cycles, busy=0.
- Read: req1, rw1=1, addr1=7'h22; m_stop=1 with m_rdata=8'hA5. Expect m_rd strobe 4 cycles, done1 pulse, rdata1=8'hA5 held afterwards.
- Contention: req0 and req1 both high from reset. Expect grant order 0,1,0,1 over four transactions, no ack overlap.
- Locked read-after-write: lock0=1 with a write then a read to 7'h51. Expect m_hold=1 across both, no GAP between, second ack0 in the DONE cycle, then m_hold=0.
- Reset mid-WAIT: assert rst during WAIT. Expect all outputs 0 the same cycle, no done0; after release, a pending req1 is granted normally.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50): m_stop never rises. Expect done0 and err0 after 50 WAIT cycles, rdata0=8'hFF. Without the macro, busy stays 1.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// Two-port round-robin arbiter in front of a single I2C master; supports locked repeated-start chains.
// Build option: define I2C_ARB_TIMEOUT_EN to add the WAIT-state watchdog (err0/err1 otherwise tied 0).
module i2c_txn_arbiter #(
  parameter int unsigned CS_CYCLES      = 4,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic       lock0,
  input  logic       lock1,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       m_cs,
  output logic       m_wr,
  output logic       m_rd,
  output logic [6:0] m_addr,
  output logic [7:0] m_wdata,
  output logic       m_hold,
  input  logic       m_stop,
  input  logic [7:0] m_rdata,
  output logic       busy
);

  if (CS_CYCLES < 1 || CS_CYCLES > 15 || GAP_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("i2c_txn_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StGap} state_e;

  localparam logic [7:0] CsLast  = 8'(CS_CYCLES - 1);
  localparam logic [7:0] GapLast = 8'(GAP_CYCLES - 1);
  localparam bit         GapZero = (GAP_CYCLES == 0);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        hold_q, hold_d;
  logic        ack_q, ack_d;
  logic [7:0]  rdata0_q, rdata0_d;
  logic [7:0]  rdata1_q, rdata1_d;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tcnt_q, tcnt_d;
  logic        err_q, err_d;
`endif

  logic pick;
  logic lock_take;
  logic err_cur;
  logic load;

  always_comb begin
    pick = (req0 && req1) ? ~last_grant_q : req1;
`ifdef I2C_ARB_TIMEOUT_EN
    err_cur = err_q;
`else
    err_cur = 1'b0;
`endif
    // An errored transaction never continues a locked chain.
    lock_take = (state_q == StDone) && !err_cur &&
                (gnt_q ? (lock1 && req1) : (lock0 && req0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      hold_q       <= 1'b0;
      ack_q        <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      hold_q       <= hold_d;
      ack_q        <= ack_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    hold_d       = hold_q;
    ack_d        = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    load         = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    tcnt_d       = '0;
    err_d        = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          load    = 1'b1;
          gnt_d   = pick;
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (cnt_q == CsLast) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWait: begin
        if (m_stop) begin
          if (rw_q) begin
            if (gnt_q) rdata1_d = m_rdata;
            else       rdata0_d = m_rdata;
          end
          state_d = StDone;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (tcnt_q == TmoLast) begin
          err_d = 1'b1;
          if (gnt_q) rdata1_d = 8'hFF;
          else       rdata0_d = 8'hFF;
          state_d = StDone;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
`endif
      end
      StDone: begin
        last_grant_d = gnt_q;
        cnt_d        = '0;
`ifdef I2C_ARB_TIMEOUT_EN
        err_d        = 1'b0;
`endif
        if (lock_take) begin
          // Repeated start: reload from the same port, no arbitration and no bus-free gap.
          load    = 1'b1;
          hold_d  = 1'b1;
          state_d = StIssue;
        end else begin
          hold_d  = 1'b0;
          state_d = GapZero ? StIdle : StGap;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      rw_d    = gnt_d ? rw1    : rw0;
      addr_d  = gnt_d ? addr1  : addr0;
      wdata_d = gnt_d ? wdata1 : wdata0;
    end
  end

  logic issue;
  logic in_done;

  always_comb begin
    issue   = (state_q == StIssue);
    in_done = (state_q == StDone);
    busy    = (state_q != StIdle);
    m_cs    = issue;
    m_wr    = issue & ~rw_q;
    m_rd    = issue & rw_q;
    m_hold  = in_done ? lock_take : hold_q;
    m_addr  = addr_q;
    m_wdata = wdata_q;
    done0   = in_done & ~gnt_q;
    done1   = in_done & gnt_q;
    err0    = in_done & ~gnt_q & err_cur;
    err1    = in_done & gnt_q & err_cur;
    ack0    = (ack_q | lock_take) & ~gnt_q;
    ack1    = (ack_q | lock_take) & gnt_q;
    rdata0  = rdata0_q;
    rdata1  = rdata1_q;
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: directed scenarios plus randomized round-robin traffic.
// Covers the I2C_ARB_TIMEOUT_EN build as well when that macro is defined.
module tb_i2c_txn_arbiter;

  localparam int CS  = 4;
  localparam int GAP = 8;
  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 0, req1 = 0, rw0 = 0, rw1 = 0, lock0 = 0, lock1 = 0;
  logic [6:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic       m_stop = 0;
  logic [7:0] m_rdata = 0;
  logic       ack0, ack1, done0, done1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic       m_cs, m_wr, m_rd, m_hold, busy;
  logic [6:0] m_addr;
  logic [7:0] m_wdata;

  int         n_checks = 0;
  int         n_errors = 0;
  int         last = 1;
  logic [7:0] exp_rd [2];

  i2c_txn_arbiter #(
    .CS_CYCLES      (CS),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .rw0     (rw0),
    .rw1     (rw1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wdata0  (wdata0),
    .wdata1  (wdata1),
    .lock0   (lock0),
    .lock1   (lock1),
    .ack0    (ack0),
    .ack1    (ack1),
    .done0   (done0),
    .done1   (done1),
    .err0    (err0),
    .err1    (err1),
    .rdata0  (rdata0),
    .rdata1  (rdata1),
    .m_cs    (m_cs),
    .m_wr    (m_wr),
    .m_rd    (m_rd),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_hold  (m_hold),
    .m_stop  (m_stop),
    .m_rdata (m_rdata),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation stalled");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs();
    logic [63:0] v;
    v = 64'({ack0, ack1, done0, done1, err0, err1, rdata0, rdata1, m_cs, m_wr, m_rd,
             m_addr, m_wdata, m_hold, busy});
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    {req0, req1, rw0, rw1, lock0, lock1, m_stop} = '0;
    {addr0, addr1, wdata0, wdata1, m_rdata} = '0;
    #1;
    check_eq("rst_outs", outs(), 64'd0);
    repeat (2) clk1();
    rst = 1'b0;
    clk1();
    check_eq("post_rst_outs", outs(), 64'd0);
    last = 1;
    exp_rd[0] = 8'h00;
    exp_rd[1] = 8'h00;
  endtask

  // Counts strobe cycles starting at the current (first ISSUE) sample; ends on the first WAIT sample.
  task automatic count_cs(input logic rw, output int n, output int s);
    n = 0;
    s = 0;
    while (m_cs && n < 32) begin
      n++;
      if ((rw ? m_rd : m_wr) && !(rw ? m_wr : m_rd)) s++;
      clk1();
    end
  endtask

  task automatic check_gap();
    int n = 0;
    do begin
      clk1();
      n++;
    end while (busy && n < 300);
    check_eq("gap_len", 64'(n - 1), 64'(GAP));
  endtask

  // Serve one transaction whose requests are already driven; stop_dly < 0 raises m_stop during ISSUE.
  task automatic serve(input int exp_port, input int stop_dly, input logic [7:0] rd,
                       input bit drop_req, output int lat);
    int         n, s, win;
    bit         got, early;
    logic       rw_w;
    logic [6:0] a_w;
    logic [7:0] d_w;
    got = 0;
    lat = 0;
    for (int i = 0; i < 64; i++) begin
      clk1();
      if (ack0 || ack1) begin
        got = 1;
        lat = i + 1;
        break;
      end
    end
    check_eq("ack_seen", 64'(got), 64'd1);
    if (!got) return;
    check_eq("ack_excl", 64'(ack0 & ack1), 64'd0);
    win  = ack1 ? 1 : 0;
    rw_w = win ? rw1 : rw0;
    a_w  = win ? addr1 : addr0;
    d_w  = win ? wdata1 : wdata0;
    check_eq("grant", 64'(win), 64'(exp_port));
    check_eq("m_addr", 64'(m_addr), 64'(a_w));
    check_eq("m_wdata", 64'(m_wdata), 64'(d_w));
    if (drop_req) begin
      if (win == 1) req1 = 1'b0;
      else          req0 = 1'b0;
    end
    if (stop_dly < 0) begin
      m_stop  = 1'b1;
      m_rdata = rd;
    end
    count_cs(rw_w, n, s);
    check_eq("cs_len", 64'(n), 64'(CS));
    check_eq("strobe_len", 64'(s), 64'(CS));
    early = 0;
    for (int i = 0; i < stop_dly; i++) begin
      clk1();
      if (done0 || done1) early = 1;
    end
    check_eq("no_early_done", 64'(early), 64'd0);
    m_stop  = 1'b1;
    m_rdata = rd;
    clk1();
    check_eq("done0", 64'(done0), 64'(win == 0));
    check_eq("done1", 64'(done1), 64'(win == 1));
    check_eq("done_err", 64'(err0 | err1), 64'd0);
    check_eq("done_noack", 64'(ack0 | ack1 | m_hold), 64'd0);
    if (rw_w) exp_rd[win] = rd;
    check_eq("rdata0", 64'(rdata0), 64'(exp_rd[0]));
    check_eq("rdata1", 64'(rdata1), 64'(exp_rd[1]));
    m_stop  = 1'b0;
    m_rdata = 8'h00;
    last    = win;
  endtask

  initial begin
    int  lat, n, s, exp;
    bit  flag;

    // Single write on port 0.
    do_reset();
    req0 = 1; rw0 = 0; addr0 = 7'h51; wdata0 = 8'h14;
    serve(0, 0, 8'h00, 1, lat);
    check_eq("wr_lat", 64'(lat), 64'd1);
    check_gap();
    check_eq("wr_idle", 64'(busy), 64'd0);

    // Read on port 1 with a delayed stop.
    req1 = 1; rw1 = 1; addr1 = 7'h22; wdata1 = 8'h00;
    serve(1, 3, 8'hA5, 1, lat);
    check_gap();
    check_eq("rd_held", 64'(rdata1), 64'hA5);

    // Contention: both held high, alternating grants.
    do_reset();
    req0 = 1; rw0 = 0; addr0 = 7'h10; wdata0 = 8'h01;
    req1 = 1; rw1 = 1; addr1 = 7'h20; wdata1 = 8'h02;
    serve(0, 1, 8'h00, 0, lat);  check_gap();
    serve(1, 0, 8'h5A, 0, lat);  check_gap();
    serve(0, 2, 8'h00, 0, lat);  check_gap();
    serve(1, -1, 8'hC3, 0, lat); check_gap();
    req0 = 0; req1 = 0;

    // Locked write followed by read, no gap in between.
    req0 = 1; rw0 = 0; addr0 = 7'h51; wdata0 = 8'h42; lock0 = 1;
    clk1();
    check_eq("lk_ack1", 64'(ack0), 64'd1);
    check_eq("lk_hold_pre", 64'(m_hold), 64'd0);
    rw0 = 1;
    count_cs(1'b0, n, s);
    check_eq("lk_cs1", 64'(n), 64'(CS));
    m_stop = 1;
    clk1();
    check_eq("lk_done1", 64'(done0), 64'd1);
    check_eq("lk_hold_done", 64'(m_hold), 64'd1);
    check_eq("lk_ack2", 64'(ack0), 64'd1);
    m_stop = 0;
    clk1();
    check_eq("lk_reissue", 64'({m_cs, m_rd, m_hold, ack0}), 64'b1110);
    check_eq("lk_addr", 64'(m_addr), 64'h51);
    req0 = 0; lock0 = 0;
    count_cs(1'b1, n, s);
    check_eq("lk_rd_strobe", 64'(s), 64'(CS));
    check_eq("lk_hold_wait", 64'(m_hold), 64'd1);
    m_stop = 1; m_rdata = 8'h3C;
    clk1();
    check_eq("lk_done2", 64'(done0), 64'd1);
    check_eq("lk_hold_end", 64'(m_hold), 64'd0);
    check_eq("lk_rdata", 64'(rdata0), 64'h3C);
    m_stop = 0; m_rdata = 0;
    check_gap();

    // Reset in the middle of WAIT with a pending port-1 request.
    do_reset();
    req0 = 1; rw0 = 0; addr0 = 7'h33; wdata0 = 8'h99;
    clk1();
    check_eq("rw_ack0", 64'(ack0), 64'd1);
    req0 = 0;
    req1 = 1; rw1 = 0; addr1 = 7'h44; wdata1 = 8'h55;
    count_cs(1'b0, n, s);
    clk1();
    rst = 1;
    #1;
    check_eq("rw_outs_zero", outs(), 64'd0);
    flag = 0;
    repeat (3) begin
      clk1();
      if (done0 || done1) flag = 1;
    end
    check_eq("rw_no_done", 64'(flag), 64'd0);
    rst = 0;
    last = 1;
    exp_rd[0] = 0;
    exp_rd[1] = 0;
    serve(1, 1, 8'h00, 1, lat);
    check_eq("rw_lat", 64'(lat), 64'd1);
    check_gap();

    // Master never signals stop.
    do_reset();
    req0 = 1; rw0 = 1; addr0 = 7'h0F;
    clk1();
    check_eq("to_ack", 64'(ack0), 64'd1);
    req0 = 0;
    count_cs(1'b1, n, s);
`ifdef I2C_ARB_TIMEOUT_EN
    req0 = 1; lock0 = 1;
    for (n = 1; n < 200; n++) begin
      clk1();
      if (done0) break;
    end
    check_eq("to_wait_len", 64'(n), 64'(TMO));
    check_eq("to_done_err", 64'({done0, err0}), 64'b11);
    check_eq("to_rdata", 64'(rdata0), 64'hFF);
    check_eq("to_no_lock", 64'({m_hold, ack0}), 64'b00);
    clk1();
    req0 = 0; lock0 = 0;
    check_eq("to_gap", 64'({busy, m_cs, err0}), 64'b100);
`else
    flag = 0;
    repeat (150) begin
      clk1();
      if (!busy || done0 || err0) flag = 1;
    end
    check_eq("no_tmo_busy", 64'(flag), 64'd0);
`endif

    // Randomized traffic against the round-robin rule.
    do_reset();
    for (int t = 0; t < 24; t++) begin
      if (!req0 && ($urandom_range(0, 1) == 1 || !req1)) begin
        req0 = 1; rw0 = 1'($urandom); addr0 = 7'($urandom); wdata0 = 8'($urandom);
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1; rw1 = 1'($urandom); addr1 = 7'($urandom); wdata1 = 8'($urandom);
      end
      exp = (req0 && req1) ? 1 - last : (req1 ? 1 : 0);
      serve(exp, int'($urandom_range(0, 4)) - 1, 8'($urandom), 1, lat);
      check_eq("rnd_lat", 64'(lat), 64'd1);
      check_gap();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
